// File: rtl/pong_vga_renderer.sv
// Pong display back end: 640x480-style VGA timing, ball and paddle rendering
// from per-frame snapshots of the game state, and a frame tick for the game logic.
module pong_vga_renderer #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int BALL_SIZE     = 10,
  parameter int PADDLE_WIDTH  = 10,
  parameter int PADDLE_HEIGHT = 60,
  parameter int PADDLE_X      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_y,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [10:0] BALL_SPAN = 11'(BALL_SIZE - 1);
  localparam logic [10:0] PAD_X0    = 11'(PADDLE_X);
  localparam logic [10:0] PAD_X1    = 11'(PADDLE_X + PADDLE_WIDTH - 1);
  localparam logic [10:0] PAD_SPAN  = 11'(PADDLE_HEIGHT - 1);

  localparam logic [5:0] C_BALL   = 6'b111111;
  localparam logic [5:0] C_PADDLE = 6'b001100;
  localparam logic [5:0] C_BG     = 6'b000001;
  localparam logic [5:0] C_BLANK  = 6'b000000;

  logic [9:0]  h_cnt, v_cnt;
  logic [9:0]  sb_x, sb_y, sp_y;
  logic [10:0] h_ext, v_ext;
  logic        active, ball_hit, paddle_hit, snap_point;
  logic [5:0]  next_rgb;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    h_ext      = {1'b0, h_cnt};
    v_ext      = {1'b0, v_cnt};
    active     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    snap_point = (h_cnt == H_LAST) && (v_cnt == V_VIS_LAST);
    // 11-bit range ends keep shapes near 1023 from wrapping back onto row/column 0.
    ball_hit   = (h_ext >= {1'b0, sb_x}) && (h_ext <= {1'b0, sb_x} + BALL_SPAN) &&
                 (v_ext >= {1'b0, sb_y}) && (v_ext <= {1'b0, sb_y} + BALL_SPAN);
    paddle_hit = (h_ext >= PAD_X0) && (h_ext <= PAD_X1) &&
                 (v_ext >= {1'b0, sp_y}) && (v_ext <= {1'b0, sp_y} + PAD_SPAN);
    next_rgb   = C_BLANK;
    if (active) begin
      if (ball_hit)        next_rgb = C_BALL;
      else if (paddle_hit) next_rgb = C_PADDLE;
      else                 next_rgb = C_BG;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= C_BLANK;
      frame_tick <= 1'b0;
      sb_x       <= 10'd320;
      sb_y       <= 10'd240;
      sp_y       <= 10'd210;
    end else begin
      frame_tick <= pix_ce && snap_point;
      if (pix_ce) begin
        // Outputs describe the pixel being left, giving one pixel of latency.
        hsync <= !((h_cnt >= HS_START) && (h_cnt <= HS_END));
        vsync <= !((v_cnt >= VS_START) && (v_cnt <= VS_END));
        rgb   <= next_rgb;
        if (snap_point) begin
          sb_x <= ball_x;
          sb_y <= ball_y;
          sp_y <= paddle_y;
        end
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Directed bench for pong_vga_renderer on a shrunken 60x38 raster; a raster-position
// model in the bench decides which pixel each sampled output belongs to.
module tb_pong_vga_renderer;

  localparam int HA = 40, HF = 4, HS = 8, HB = 8;
  localparam int VA = 30, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;   // 60
  localparam int VT = VA + VF + VS + VB;   // 38
  localparam int FRAME = HT * VT;          // 2280 clocks

  localparam logic [5:0] C_BALL = 6'b111111;
  localparam logic [5:0] C_PAD  = 6'b001100;
  localparam logic [5:0] C_BG   = 6'b000001;
  localparam logic [5:0] C_OFF  = 6'b000000;

  logic       clk = 1'b0;
  logic       rst, pix_ce;
  logic [9:0] ball_x, ball_y, paddle_y;
  logic       hsync, vsync, frame_tick;
  logic [5:0] rgb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_tick = -1;
  int mh = 0, mv = 0;
  bit toggle = 1'b0;

  pong_vga_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BALL_SIZE(4), .PADDLE_WIDTH(3), .PADDLE_HEIGHT(6), .PADDLE_X(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given enable; the raster model follows what the DUT should do.
  task automatic clk1(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    if (rst) begin
      mh = 0;
      mv = 0;
    end else if (ce) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    @(negedge clk);
  endtask

  task automatic adv();
    if (toggle) begin
      clk1(1'b0);
      clk1(1'b1);
    end else begin
      clk1(1'b1);
    end
  endtask

  task automatic goto(input int x, input int y);
    while (!(mh == x && mv == y)) adv();
  endtask

  // After this, hsync/vsync/rgb describe pixel (x,y).
  task automatic at(input int x, input int y);
    goto(x, y);
    adv();
  endtask

  task automatic px(input int x, input int y, input logic [5:0] exp);
    at(x, y);
    check($sformatf("rgb(%0d,%0d)", x, y), 32'(rgb), 32'(exp));
  endtask

  task automatic frame_end(input int period);
    goto(HT - 1, VA - 1);
    check("tick_before_load", 32'(frame_tick), 32'd0);
    adv();
    check("tick_pulse", 32'(frame_tick), 32'd1);
    if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 32'(period));
    last_tick = cyc;
    adv();
    check("tick_after_pulse", 32'(frame_tick), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pix_ce = 1'b1;
    ball_x = '0; ball_y = '0; paddle_y = '0;
    clk1(1'b1);
    clk1(1'b1);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'(rgb), 32'(C_OFF));
    check("rst_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    // Frame 0: reset snapshots are off this small screen; new inputs wait for the snapshot.
    ball_x = 10'd10; ball_y = 10'd5; paddle_y = 10'd12;
    at(0, 0);
    check("f0_rgb(0,0)", 32'(rgb), 32'(C_BG));
    check("f0_hsync(0,0)", 32'(hsync), 32'd1);
    check("f0_vsync(0,0)", 32'(vsync), 32'd1);
    px(2, 0, C_BG);
    px(10, 5, C_BG);
    px(39, 5, C_BG);
    px(40, 5, C_OFF);
    at(43, 5); check("hsync(43)", 32'(hsync), 32'd1);
    at(44, 5); check("hsync(44)", 32'(hsync), 32'd0);
    at(51, 5); check("hsync(51)", 32'(hsync), 32'd0);
    at(52, 5); check("hsync(52)", 32'(hsync), 32'd1);
    frame_end(FRAME);
    at(0, 31); check("vsync(31)", 32'(vsync), 32'd1);
    at(0, 32); check("vsync(32)", 32'(vsync), 32'd0);
    check("rgb_vblank", 32'(rgb), 32'(C_OFF));
    at(0, 33); check("vsync(33)", 32'(vsync), 32'd0);
    at(0, 34); check("vsync(34)", 32'(vsync), 32'd1);

    // Frame 1: ball (10,5), paddle rows 12..17; ball_x moves mid-frame without effect.
    goto(0, 3);
    ball_x = 10'd25;
    px(10, 4, C_BG);
    px(9, 5, C_BG);
    px(10, 5, C_BALL);
    px(13, 5, C_BALL);
    px(14, 5, C_BG);
    px(13, 8, C_BALL);
    px(13, 9, C_BG);
    px(1, 12, C_BG);
    px(2, 12, C_PAD);
    px(4, 12, C_PAD);
    px(5, 12, C_BG);
    px(2, 17, C_PAD);
    px(2, 18, C_BG);
    frame_end(FRAME);

    // Frame 2: the moved ball appears only now.
    px(10, 5, C_BG);
    px(25, 5, C_BALL);
    px(28, 8, C_BALL);
    ball_x = 10'd3; ball_y = 10'd14; paddle_y = 10'd12;
    frame_end(FRAME);

    // Frame 3: ball columns 3..6 overlap paddle columns 2..4; ball wins.
    px(2, 14, C_PAD);
    px(3, 14, C_BALL);
    px(4, 14, C_BALL);
    px(6, 14, C_BALL);
    px(7, 14, C_BG);
    px(2, 17, C_PAD);
    px(4, 17, C_BALL);
    px(4, 18, C_BG);
    ball_x = 10'd38; ball_y = 10'd1020; paddle_y = 10'd27;
    frame_end(FRAME);

    // Frame 4: ball rows 1020..1023 must not wrap to the top; paddle clipped at bottom.
    px(0, 0, C_BG);
    px(1, 0, C_BG);
    px(38, 0, C_BG);
    px(39, 1, C_BG);
    px(2, 27, C_PAD);
    px(2, 29, C_PAD);
    px(38, 29, C_BG);
    ball_y = 10'd28;
    frame_end(FRAME);

    // Frame 5: ball clipped at the right and bottom edges.
    px(2, 27, C_PAD);
    px(37, 28, C_BG);
    px(38, 28, C_BALL);
    px(0, 29, C_BG);
    px(39, 29, C_BALL);
    px(40, 29, C_OFF);
    frame_end(FRAME);

    // Frames 6-7: enable toggles every clock, so the tick period doubles.
    toggle = 1'b1;
    last_tick = -1;
    px(38, 28, C_BALL);
    clk1(1'b0);
    check("hold_rgb", 32'(rgb), 32'(C_BALL));
    check("hold_tick", 32'(frame_tick), 32'd0);
    frame_end(2 * FRAME);
    at(44, 3); check("tog_hsync(44)", 32'(hsync), 32'd0);
    frame_end(2 * FRAME);

    // Frame 8: reset mid-frame restarts the raster and reloads the snapshots.
    px(0, 20, C_BG);
    rst = 1'b1;
    clk1(1'b1);
    check("mid_rst_hsync", 32'(hsync), 32'd1);
    check("mid_rst_vsync", 32'(vsync), 32'd1);
    check("mid_rst_rgb", 32'(rgb), 32'(C_OFF));
    check("mid_rst_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    px(0, 0, C_BG);
    px(38, 28, C_BG);
    at(44, 28); check("post_rst_hsync(44)", 32'(hsync), 32'd0);
    at(0, 32);  check("post_rst_vsync(32)", 32'(vsync), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_vga_renderer.md
PONG_VGA_RENDERER -- requirements
Module: pong_vga_renderer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48 (line total 800).
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33 (frame total 525).
REQ-005 SHALL have parameters BALL_SIZE, default 10; PADDLE_WIDTH, default 10; PADDLE_HEIGHT, default 60; PADDLE_X, default 0 (left edge column of paddle).
REQ-006 clk  input  1  pixel-domain clock; all state on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 pix_ce  input  1  pixel clock-enable; counters and outputs advance only when high.
REQ-009 ball_x  input  10  ball left column from game logic.
REQ-010 ball_y  input  10  ball top row from game logic.
REQ-011 paddle_y  input  10  paddle top row from game logic.
REQ-012 hsync  output  1  horizontal sync, active-low.
REQ-013 vsync  output  1  vertical sync, active-low.
REQ-014 rgb  output  6  {R[1:0],G[1:0],B[1:0]} pixel colour.
REQ-015 frame_tick  output  1  one-clk pulse at start of vertical blank; game logic advances on it.

Function
REQ-016 h_cnt (10b) SHALL count 0..799 on each clk with pix_ce=1, wrapping 799->0.
REQ-017 v_cnt (10b) SHALL increment only when h_cnt wraps 799->0, counting 0..524, wrapping 524->0.
REQ-018 With pix_ce=0 all counters, snapshots and outputs SHALL hold, except frame_tick which SHALL be 0.
REQ-019 hsync SHALL be 0 iff h_cnt in [656,751]; vsync SHALL be 0 iff v_cnt in [490,491].
REQ-020 active region SHALL be h_cnt<640 and v_cnt<480; rgb SHALL be 6'b000000 outside it.
REQ-021 ball hit SHALL be h_cnt in [sb_x, sb_x+BALL_SIZE-1] and v_cnt in [sb_y, sb_y+BALL_SIZE-1], using snapshot values.
REQ-022 paddle hit SHALL be h_cnt in [PADDLE_X, PADDLE_X+PADDLE_WIDTH-1] and v_cnt in [sp_y, sp_y+PADDLE_HEIGHT-1].
REQ-023 Range compares SHALL use 11-bit sums so ends beyond 1023 do not wrap; shapes partly off-screen clip silently.
REQ-024 Colour priority SHALL be ball (6'b111111) > paddle (6'b001100) > background (6'b000001).
REQ-025 hsync, vsync, rgb SHALL be registered; each reflects the h_cnt/v_cnt value present one pix_ce step earlier (latency 1 pixel), all three aligned.
REQ-026 Snapshot sb_x, sb_y, sp_y SHALL load from ball_x, ball_y, paddle_y on the pix_ce clk where h_cnt=799 and v_cnt=479 (last visible pixel), and hold for the whole next frame.
REQ-027 frame_tick SHALL be 1 for exactly one clk, on the clk after the snapshot load, once per frame.
REQ-028 Input changes during the active region SHALL NOT alter the current frame image.

Reset
REQ-029 On rst=1 at a clk edge: h_cnt=0, v_cnt=0, hsync=1, vsync=1, rgb=0, frame_tick=0.
REQ-030 On reset, snapshots SHALL load sb_x=320, sb_y=240, sp_y=210.
REQ-031 rst SHALL take priority over pix_ce; reset mid-frame SHALL restart at pixel (0,0) on the first pix_ce after release.

Verification
REQ-032 pix_ce=1 constant, 2 frames -> 420000 clks between frame_tick pulses; hsync low 96 pixels/line, vsync low 2 lines/frame (1600 clks).
REQ-033 ball_x=100, ball_y=50, paddle_y=200, held one frame -> next frame rgb=111111 at pixels (100..109, 50..59), 001100 at (0..9, 200..259), 000001 elsewhere visible.
REQ-034 ball_x=5, paddle_y=230 overlapping paddle columns 5..9 -> overlap pixels 111111 (ball wins).
REQ-035 change ball_x 100->400 at v_cnt=200 -> current frame unchanged; new position drawn only after next frame_tick.
REQ-036 ball_x=635, ball_y=1020 -> no wrap artefacts at column 0 or row 0; clipped drawing only.
REQ-037 pix_ce toggling 1/0 each clk -> frame_tick period doubles to 840000 clks; assert rst at v_cnt=300 -> outputs 1,1,0 and counters restart at 0.
